// File: rtl/updown_pkg.sv
// updown_pkg
// Shared types and the direction helper for the up/down stepper.
//   state_e  : controller states (IDLE waits for a target, MOVE emits pulses)
//   dir_e    : stepping direction latched at target acceptance
//   pick_dir : chooses up or down from the current count, the target and the
//              wrap mode; the design and its scoreboard both call it
package updown_pkg;

    typedef enum logic {IDLE, MOVE} state_e;

    typedef enum logic {DIR_UP, DIR_DOWN} dir_e;

    // Operands are passed zero-extended to 32 bits so the one function serves
    // any counter width. With wrapping allowed, the upward modular distance
    // is compared against half the range, and an exact half-way tie goes up.
    // Without wrapping, the count moves monotonically toward the target.
    function automatic dir_e pick_dir(input logic [31:0] shadow,
                                      input logic [31:0] target,
                                      input logic        wrap_en,
                                      input int          width = 4);
        logic [31:0] half;
        logic [31:0] mask;
        logic [31:0] d_up;
        half = 32'd1 << (width - 1);
        mask = (half << 1) - 32'd1;
        d_up = (target - shadow) & mask;
        if (wrap_en) begin
            return (d_up <= half) ? DIR_UP : DIR_DOWN;
        end
        return (target > shadow) ? DIR_UP : DIR_DOWN;
    endfunction

endpackage

// File: rtl/step_timer.sv
// step_timer
// Pulse-spacing prescaler. It is started by each emitted pulse and raises
// tick in the cycle before the next pulse is due, so that the registered
// pulse lands exactly STEP_DIV cycles after the previous one.
//   clk, reset : clock and asynchronous active-high reset
//   start      : a pulse is high in this cycle
//   clear      : abandon any pending interval (move finished or aborted)
//   tick       : load the next pulse at the coming edge
module step_timer #(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic clear,
    output logic tick
);

    localparam int CW = $clog2(STEP_DIV + 1);
    localparam logic [CW-1:0] RELOAD = CW'(STEP_DIV - 1);

    logic [CW-1:0] cnt;

    // Counts down the cycles remaining until the next pulse. A pulse loads
    // STEP_DIV-1, so the count sits at 1 in the last cycle before the next
    // pulse is due; clear takes priority so a finished move leaves nothing
    // pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - CW'(1);
        end
    end

    // With no division the next pulse follows immediately, so the pulse
    // itself requests its successor.
    assign tick = (STEP_DIV == 1) ? start : (cnt == CW'(1));

endmodule

// File: rtl/updown_stepper.sv
// updown_stepper
// Command-side driver for the 4-bit up/down counter. It accepts a target over
// a valid/ready handshake and emits one-cycle up or down pulses until its
// shadow copy of the counter equals the target.
//   clk, reset    : clock and asynchronous active-high reset
//   tgt_valid     : a target is offered
//   tgt_ready     : target can be accepted (IDLE only)
//   tgt_value     : requested final count
//   wrap_en       : sampled with the target; 1 takes the shortest modular path
//   abort         : stop stepping after the current pulse
//   up, down      : increment / decrement pulses to the counter
//   shadow_count  : mirror of the counter value
//   busy          : high while moving
//   done          : one-cycle pulse when the target is reached
module updown_stepper
    import updown_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_value,
    input  logic             wrap_en,
    input  logic             abort,
    output logic             up,
    output logic             down,
    output logic [WIDTH-1:0] shadow_count,
    output logic             busy,
    output logic             done
);

    state_e           state, state_next;
    dir_e             dir_q, dir_next, start_dir;
    logic [WIDTH-1:0] target_q, target_next;
    logic [WIDTH-1:0] stepped;
    logic             pulse, reached, tick, timer_clear;
    logic             up_next, down_next, done_next;

    assign pulse     = up | down;
    assign stepped   = !pulse ? shadow_count :
                       (dir_q == DIR_UP) ? shadow_count + WIDTH'(1)
                                         : shadow_count - WIDTH'(1);
    assign reached   = (state == MOVE) && pulse && (stepped == target_q);
    assign start_dir = pick_dir(32'(shadow_count), 32'(tgt_value), wrap_en, WIDTH);

    // The interval restarts on every pulse and is dropped whenever the move
    // ends, whether by completion or abort.
    assign timer_clear = (state != MOVE) || reached || abort;

    step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
        .clk   (clk),
        .reset (reset),
        .start (pulse),
        .clear (timer_clear),
        .tick  (tick)
    );

    // State register together with the target and direction latched at
    // acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            target_q <= '0;
            dir_q    <= DIR_UP;
        end else begin
            state    <= state_next;
            target_q <= target_next;
            dir_q    <= dir_next;
        end
    end

    // Next-state logic. A target equal to the current count completes without
    // leaving IDLE. In MOVE, completion and abort both return to IDLE; a pulse
    // that is high while abort is sampled has already been counted through
    // stepped, so reached covers the abort-on-last-pulse case.
    always_comb begin
        state_next  = state;
        target_next = target_q;
        dir_next    = dir_q;
        case (state)
            IDLE: begin
                if (tgt_valid && (tgt_value != shadow_count)) begin
                    state_next  = MOVE;
                    target_next = tgt_value;
                    dir_next    = start_dir;
                end
            end
            MOVE: begin
                if (reached || abort) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs. The first pulse is loaded at the
    // acceptance edge so it appears in the very next cycle; later pulses wait
    // for the timer. Completion takes priority over abort.
    always_comb begin
        up_next   = 1'b0;
        down_next = 1'b0;
        done_next = 1'b0;
        case (state)
            IDLE: begin
                if (tgt_valid) begin
                    if (tgt_value == shadow_count) begin
                        done_next = 1'b1;
                    end else begin
                        up_next   = (start_dir == DIR_UP);
                        down_next = (start_dir == DIR_DOWN);
                    end
                end
            end
            MOVE: begin
                if (reached) begin
                    done_next = 1'b1;
                end else if (!abort && tick) begin
                    up_next   = (dir_q == DIR_UP);
                    down_next = (dir_q == DIR_DOWN);
                end
            end
            default: ;
        endcase
    end

    // Output registers. shadow_count advances at the same edge that samples
    // each pulse, which is the edge at which the real counter moves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up           <= 1'b0;
            down         <= 1'b0;
            done         <= 1'b0;
            shadow_count <= '0;
        end else begin
            up           <= up_next;
            down         <= down_next;
            done         <= done_next;
            shadow_count <= stepped;
        end
    end

    // Handshake and busy are plain decodes of the state register.
    assign tgt_ready = (state == IDLE);
    assign busy      = (state == MOVE);

endmodule

// File: tb/tb_updown_stepper.sv
// tb_updown_stepper
// Directed and randomised checks of updown_stepper: one instance with
// back-to-back pulses (STEP_DIV=1) and one with STEP_DIV=3.
module tb_updown_stepper;
    import updown_pkg::*;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic       a_valid, a_wrap, a_abort;
    logic [3:0] a_value;
    logic       a_ready, a_up, a_down, a_busy, a_done;
    logic [3:0] a_shadow;
    logic       b_valid, b_wrap, b_abort;
    logic [3:0] b_value;
    logic       b_ready, b_up, b_down, b_busy, b_done;
    logic [3:0] b_shadow;

    int vecCount  = 0;
    int missCount = 0;

    logic [3:0] model_a;

    always #5 clk = ~clk;

    updown_stepper #(.WIDTH(4), .STEP_DIV(1)) dut_a (
        .clk          (clk),
        .reset        (rst_a),
        .tgt_valid    (a_valid),
        .tgt_ready    (a_ready),
        .tgt_value    (a_value),
        .wrap_en      (a_wrap),
        .abort        (a_abort),
        .up           (a_up),
        .down         (a_down),
        .shadow_count (a_shadow),
        .busy         (a_busy),
        .done         (a_done)
    );

    updown_stepper #(.WIDTH(4), .STEP_DIV(3)) dut_b (
        .clk          (clk),
        .reset        (rst_b),
        .tgt_valid    (b_valid),
        .tgt_ready    (b_ready),
        .tgt_value    (b_value),
        .wrap_en      (b_wrap),
        .abort        (b_abort),
        .up           (b_up),
        .down         (b_down),
        .shadow_count (b_shadow),
        .busy         (b_busy),
        .done         (b_done)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Behavioural counter driven by the pulses, as the real counter would be.
    always @(posedge clk or posedge rst_a) begin
        if (rst_a) begin
            model_a <= 4'd0;
        end else if (a_up) begin
            model_a <= model_a + 4'd1;
        end else if (a_down) begin
            model_a <= model_a - 4'd1;
        end
    end

    always @(negedge clk) begin
        if (!rst_a) begin
            checkOutput("sb shadow", 32'(a_shadow), 32'(model_a));
            checkOutput("sb exclusive", 32'(a_up & a_down), 0);
        end
    end

    // One move on instance A: offer the target, expect n pulses in cycles
    // 1..n after acceptance and done in cycle n+1. When intrude is set a
    // second target is offered in cycle 2 and must be refused.
    task automatic applyStimulus(input string tag, input int start, input int tgt,
                                 input bit wrap, input int n, input bit goUp,
                                 input bit intrude);
        @(negedge clk);
        a_valid = 1'b1;
        a_value = 4'(tgt);
        a_wrap  = wrap;
        checkOutput({tag, " ready"}, 32'(a_ready), 1);
        @(negedge clk);
        a_valid = 1'b0;
        for (int c = 1; c <= n; c++) begin
            if (intrude && c == 2) begin
                a_valid = 1'b1;
                a_value = 4'd3;
                checkOutput({tag, " ready busy"}, 32'(a_ready), 0);
            end else begin
                a_valid = 1'b0;
            end
            checkOutput({tag, " up"}, 32'(a_up), 32'(goUp));
            checkOutput({tag, " down"}, 32'(a_down), 32'(!goUp));
            checkOutput({tag, " busy"}, 32'(a_busy), 1);
            checkOutput({tag, " early done"}, 32'(a_done), 0);
            checkOutput({tag, " shadow step"}, 32'(a_shadow),
                        goUp ? ((start + c - 1) & 15) : ((start - c + 1) & 15));
            @(negedge clk);
        end
        a_valid = 1'b0;
        checkOutput({tag, " done"}, 32'(a_done), 1);
        checkOutput({tag, " final shadow"}, 32'(a_shadow), tgt);
        checkOutput({tag, " final ready"}, 32'(a_ready), 1);
        checkOutput({tag, " final busy"}, 32'(a_busy), 0);
        checkOutput({tag, " final pulse"}, 32'(a_up | a_down), 0);
        @(negedge clk);
        checkOutput({tag, " done width"}, 32'(a_done), 0);
    endtask

    initial begin
        int   cur, tgt, n, dup;
        bit   w;
        dir_e d;

        a_valid = 1'b0; a_wrap = 1'b0; a_abort = 1'b0; a_value = 4'd0;
        b_valid = 1'b0; b_wrap = 1'b0; b_abort = 1'b0; b_value = 4'd0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);

        checkOutput("reset ready", 32'(a_ready), 1);
        checkOutput("reset up", 32'(a_up), 0);
        checkOutput("reset down", 32'(a_down), 0);
        checkOutput("reset shadow", 32'(a_shadow), 0);
        checkOutput("reset busy", 32'(a_busy), 0);
        checkOutput("reset done", 32'(a_done), 0);

        applyStimulus("0to5",     0,  5, 1'b0,  5, 1'b1, 1'b0);
        applyStimulus("5to2",     5,  2, 1'b0,  3, 1'b0, 1'b0);
        applyStimulus("2to14w",   2, 14, 1'b1,  4, 1'b0, 1'b0);
        applyStimulus("14to2w",  14,  2, 1'b1,  4, 1'b1, 1'b0);
        applyStimulus("2to14",    2, 14, 1'b0, 12, 1'b1, 1'b0);
        applyStimulus("14to0w",  14,  0, 1'b1,  2, 1'b1, 1'b0);
        applyStimulus("0to8tie",  0,  8, 1'b1,  8, 1'b1, 1'b0);
        applyStimulus("8to7",     8,  7, 1'b0,  1, 1'b0, 1'b0);
        applyStimulus("7to7",     7,  7, 1'b0,  0, 1'b1, 1'b0);
        applyStimulus("7to10bsy", 7, 10, 1'b0,  3, 1'b1, 1'b1);

        // Abort on the pulse that completes the move: completion wins.
        @(negedge clk);
        a_valid = 1'b1; a_value = 4'd11; a_wrap = 1'b0;
        @(negedge clk);
        a_valid = 1'b0;
        a_abort = 1'b1;
        checkOutput("abortLast pulse", 32'(a_up), 1);
        @(negedge clk);
        a_abort = 1'b0;
        checkOutput("abortLast done", 32'(a_done), 1);
        checkOutput("abortLast shadow", 32'(a_shadow), 11);
        checkOutput("abortLast busy", 32'(a_busy), 0);

        cur = 11;
        for (int i = 0; i < 1000; i++) begin
            tgt = int'($urandom_range(0, 15));
            w   = 1'($urandom_range(0, 1));
            d   = pick_dir(32'(cur), 32'(tgt), w, 4);
            dup = (tgt - cur) & 15;
            if (tgt == cur) n = 0;
            else if (!w) n = (tgt > cur) ? tgt - cur : cur - tgt;
            else n = (d == DIR_UP) ? dup : 16 - dup;
            applyStimulus("rand", cur, tgt, w, n, d == DIR_UP, 1'b0);
            cur = tgt;
        end

        // STEP_DIV=3: 0 to 4 gives pulses in cycles 1,4,7,10 and done in 11.
        @(negedge clk);
        b_valid = 1'b1; b_value = 4'd4; b_wrap = 1'b0;
        @(negedge clk);
        b_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            checkOutput("div3 up", 32'(b_up), 32'(c % 3 == 1));
            checkOutput("div3 down", 32'(b_down), 0);
            checkOutput("div3 shadow", 32'(b_shadow), (c + 1) / 3);
            checkOutput("div3 busy", 32'(b_busy), 1);
            checkOutput("div3 early done", 32'(b_done), 0);
            @(negedge clk);
        end
        checkOutput("div3 done", 32'(b_done), 1);
        checkOutput("div3 final shadow", 32'(b_shadow), 4);
        checkOutput("div3 final ready", 32'(b_ready), 1);

        rst_b = 1'b1;
        #1;
        checkOutput("b reset shadow", 32'(b_shadow), 0);
        @(negedge clk);
        rst_b = 1'b0;

        // Abort during the second pulse leaves the count at 2 with no done.
        @(negedge clk);
        b_valid = 1'b1; b_value = 4'd4;
        @(negedge clk);
        b_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort 2nd pulse", 32'(b_up), 1);
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        checkOutput("abort shadow", 32'(b_shadow), 2);
        checkOutput("abort done", 32'(b_done), 0);
        checkOutput("abort busy", 32'(b_busy), 0);
        checkOutput("abort ready", 32'(b_ready), 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("abort quiet pulse", 32'(b_up | b_down), 0);
            checkOutput("abort quiet done", 32'(b_done), 0);
            checkOutput("abort quiet shadow", 32'(b_shadow), 2);
        end

        // Reset in the middle of a move clears everything at once.
        @(negedge clk);
        b_valid = 1'b1; b_value = 4'd9;
        @(negedge clk);
        b_valid = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("midreset pulse", 32'(b_up), 1);
        rst_b = 1'b1;
        #1;
        checkOutput("midreset up", 32'(b_up), 0);
        checkOutput("midreset down", 32'(b_down), 0);
        checkOutput("midreset shadow", 32'(b_shadow), 0);
        checkOutput("midreset busy", 32'(b_busy), 0);
        checkOutput("midreset done", 32'(b_done), 0);
        checkOutput("midreset ready", 32'(b_ready), 1);
        @(negedge clk);
        rst_b = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checkOutput("postreset pulse", 32'(b_up | b_down), 0);
            checkOutput("postreset shadow", 32'(b_shadow), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
